encoder_8to3: RTL and testbench

- Registered 8-to-3 priority encoder with eight single-bit request inputs i7..i0.
- Produces a 3-bit binary index y of the winning active input, a valid flag and a multi-hot flag.
- Used as a leaf block wherever a one-hot (or mostly one-hot) select must be converted to a binary index.
- All outputs are registered on clk.

---
 rtl/encoder_8to3.sv | 71 +++++++
 tb/tb_encoder_8to3.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/encoder_8to3.sv
// rtl/encoder_8to3.sv - registered 8-to-3 priority encoder with valid and multi-hot flags
// Define ENC_MULTI_HOT_DET_EN to build the multi-hot detector; otherwise multi_hot is tied to 0.
module encoder_8to3 #(
  parameter int PRIORITY_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       i7,
  input  logic       i6,
  input  logic       i5,
  input  logic       i4,
  input  logic       i3,
  input  logic       i2,
  input  logic       i1,
  input  logic       i0,
  output logic [2:0] y,
  output logic       valid,
  output logic       multi_hot
);

  logic [7:0] w_req;
  logic [2:0] w_idx;
  logic       w_any;
  logic       w_multi;

  logic [2:0] r_y;
  logic       r_valid;
  logic       r_multi;

  assign w_req = {i7, i6, i5, i4, i3, i2, i1, i0};
  assign w_any = |w_req;

  // Scan order decides the winner: the last match in the loop overrides earlier ones.
  always_comb begin
    w_idx = 3'd0;
    if (PRIORITY_HIGH != 0) begin
      for (int k = 0; k < 8; k++) begin
        if (w_req[k]) w_idx = 3'(k);
      end
    end else begin
      for (int k = 7; k >= 0; k--) begin
        if (w_req[k]) w_idx = 3'(k);
      end
    end
  end

`ifdef ENC_MULTI_HOT_DET_EN
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi = |(w_req & (w_req - 8'd1));
`else
  assign w_multi = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= 3'd0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else if (en) begin
      r_y     <= w_idx;
      r_valid <= w_any;
      r_multi <= w_multi;
    end
  end

  assign y         = r_y;
  assign valid     = r_valid;
  assign multi_hot = r_multi;

endmodule

// File: tb/tb_encoder_8to3.sv
// tb/tb_encoder_8to3.sv - self-checking bench for encoder_8to3 (both priority variants)
module tb_encoder_8to3;

`ifdef ENC_MULTI_HOT_DET_EN
  localparam logic MH_EN = 1'b1;
`else
  localparam logic MH_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en;
  logic [7:0] req;
  logic [2:0] y_hi, y_lo;
  logic       v_hi, v_lo, mh_hi, mh_lo;

  int n_pass = 0;
  int n_total = 0;

  // Model state: what the registered outputs should be after the latest edge.
  int   m_y_hi, m_y_lo;
  logic m_valid, m_mh;

  always #5 clk = ~clk;

  encoder_8to3 #(.PRIORITY_HIGH(1)) u_hi (
    .clk(clk), .rst(rst), .en(en),
    .i7(req[7]), .i6(req[6]), .i5(req[5]), .i4(req[4]),
    .i3(req[3]), .i2(req[2]), .i1(req[1]), .i0(req[0]),
    .y(y_hi), .valid(v_hi), .multi_hot(mh_hi)
  );

  encoder_8to3 #(.PRIORITY_HIGH(0)) u_lo (
    .clk(clk), .rst(rst), .en(en),
    .i7(req[7]), .i6(req[6]), .i5(req[5]), .i4(req[4]),
    .i3(req[3]), .i2(req[2]), .i1(req[1]), .i0(req[0]),
    .y(y_lo), .valid(v_lo), .multi_hot(mh_lo)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    int         y_hi;
    int         y_lo;
    logic       valid;
    logic       mh;
  } vec_t;

  vec_t vecs[$];

  function automatic int highest_set(input logic [7:0] v);
    int x = int'(v);
    int r = 0;
    while (x > 1) begin
      x = x / 2;
      r++;
    end
    return r;
  endfunction

  function automatic int lowest_set(input logic [7:0] v);
    int x = int'(v);
    int r = 0;
    if (x == 0) return 0;
    while (x % 2 == 0) begin
      x = x / 2;
      r++;
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Drive on the falling edge, let the rising edge capture, sample 1 ns later.
  task automatic step(input logic r, input logic e, input logic [7:0] q);
    @(negedge clk);
    rst = r;
    en  = e;
    req = q;
    @(posedge clk);
    if (r) begin
      m_y_hi = 0; m_y_lo = 0; m_valid = 1'b0; m_mh = 1'b0;
    end else if (e) begin
      m_y_hi  = highest_set(q);
      m_y_lo  = lowest_set(q);
      m_valid = (q != 8'h00);
      m_mh    = MH_EN && ($countones(q) >= 2);
    end
    #1;
  endtask

  task automatic check_all(input string tag, input int ey_hi, input int ey_lo,
                           input logic ev, input logic emh);
    check({tag, ".y_hi"},  int'(y_hi),  ey_hi);
    check({tag, ".y_lo"},  int'(y_lo),  ey_lo);
    check({tag, ".v_hi"},  int'(v_hi),  int'(ev));
    check({tag, ".v_lo"},  int'(v_lo),  int'(ev));
    check({tag, ".mh_hi"}, int'(mh_hi), int'(emh));
    check({tag, ".mh_lo"}, int'(mh_lo), int'(emh));
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; en = 1'b0; req = 8'h00;
    m_y_hi = 0; m_y_lo = 0; m_valid = 1'b0; m_mh = 1'b0;

    vecs.push_back('{1'b1, 1'b0, 8'hFF, 0, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'hFF, 0, 0, 1'b0, 1'b0});
    for (int k = 0; k < 8; k++)
      vecs.push_back('{1'b0, 1'b1, 8'(1 << k), k, k, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 0, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h81, 7, 0, 1'b1, MH_EN});
    vecs.push_back('{1'b0, 1'b1, 8'h24, 5, 2, 1'b1, MH_EN});
    vecs.push_back('{1'b0, 1'b1, 8'hFF, 7, 0, 1'b1, MH_EN});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 0, 0, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step(v.rst, v.en, v.req);
      check_all($sformatf("vec%0d", i), v.y_hi, v.y_lo, v.valid, v.mh);
    end

    // One-hot inputs held for 100 ns each; outputs stay steady while held.
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 8'(1 << k));
      check_all($sformatf("hold_onehot%0d", k), k, k, 1'b1, 1'b0);
    end

    // Enable hold: en=0 freezes the captured index.
    step(1'b0, 1'b1, 8'h08);
    check_all("en_cap3", 3, 3, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, 8'h40);
      check_all($sformatf("en_hold%0d", c), 3, 3, 1'b1, 1'b0);
    end
    step(1'b0, 1'b1, 8'h40);
    check_all("en_resume6", 6, 6, 1'b1, 1'b0);

    // Reset wins over en, then the next enabled edge captures normally.
    step(1'b0, 1'b1, 8'h10);
    check_all("rst_pre4", 4, 4, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h80);
    check_all("rst_clear", 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h80);
    check_all("rst_release7", 7, 7, 1'b1, 1'b0);

    // Randomised traffic against the behavioural model.
    for (int n = 0; n < 400; n++) begin
      logic r, e;
      logic [7:0] q;
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: q = 8'(1 << $urandom_range(0, 7));
        1: q = 8'h00;
        default: q = 8'($urandom);
      endcase
      step(r, e, q);
      check_all($sformatf("rand%0d", n), m_y_hi, m_y_lo, m_valid, m_mh);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
